// File: rtl/digit_overlay_vga.sv
// Seven-segment digit overlay for a VGA pixel stream, fixed 2-cycle latency.
// Optional change highlight: define DIGIT_OVL_HIGHLIGHT_EN.
module digit_overlay_vga #(
    parameter int          X0        = 300,
    parameter int          Y0        = 200,
    parameter int          SEG_LEN   = 32,
    parameter int          SEG_W     = 6,
    parameter logic [23:0] FG_RGB    = 24'hFFFFFF,
    parameter logic [23:0] HL_RGB    = 24'hFF0000,
    parameter int          HL_FRAMES = 30
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [3:0]  i_digit_in,
    input  logic        i_frame_start,
    input  logic [9:0]  i_hcount,
    input  logic [9:0]  i_vcount,
    input  logic        i_video_on,
    input  logic [23:0] i_rgb_in,
    output logic [23:0] o_rgb_out,
    output logic        o_video_on_out,
    output logic [3:0]  o_digit_latched
);

    localparam logic [10:0] S  = 11'(SEG_W);
    localparam logic [10:0] L  = 11'(SEG_LEN);
    localparam logic [10:0] XA = S;
    localparam logic [10:0] XB = S + L;
    localparam logic [10:0] XC = S + S + L;
    localparam logic [10:0] Y1 = S;
    localparam logic [10:0] Y2 = S + L;
    localparam logic [10:0] Y3 = S + S + L;
    localparam logic [10:0] Y4 = S + S + L + L;
    localparam logic [10:0] Y5 = S + S + S + L + L;

    logic [3:0]  r_digit_q;
    logic [10:0] r_rx;
    logic [10:0] r_ry;
    logic [6:0]  r_in_rng;
    logic [23:0] r_rgb_d;
    logic        r_vid_d;
    logic [23:0] r_rgb_out;
    logic        r_vid_out;

    logic [10:0] w_rx;
    logic [10:0] w_ry;
    logic        w_out;
    logic        w_col0;
    logic        w_colm;
    logic        w_col2;
    logic        w_row0;
    logic        w_rowu;
    logic        w_rowm;
    logic        w_rowl;
    logic        w_row2;
    logic [6:0]  w_in_rng;
    logic [6:0]  w_lit;
    logic        w_hit;
    logic [23:0] w_colour;

    // Digit shown for the whole frame; only sampled at the frame boundary.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_digit_q <= 4'd0;
        end else if (i_frame_start) begin
            r_digit_q <= i_digit_in;
        end
    end

`ifdef DIGIT_OVL_HIGHLIGHT_EN
    logic [7:0] r_hl_cnt;

    // Frames left to show the highlight colour after a digit change.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hl_cnt <= 8'd0;
        end else if (i_frame_start) begin
            if (i_digit_in != r_digit_q) begin
                r_hl_cnt <= 8'(HL_FRAMES);
            end else if (r_hl_cnt != 8'd0) begin
                r_hl_cnt <= r_hl_cnt - 8'd1;
            end
        end
    end

    assign w_colour = (r_hl_cnt != 8'd0) ? HL_RGB : FG_RGB;
`else
    assign w_colour = FG_RGB;
`endif

    // Box-relative coordinates and per-segment range tests for this pixel.
    always_comb begin
        w_rx   = {1'b0, i_hcount} - 11'(X0);
        w_ry   = {1'b0, i_vcount} - 11'(Y0);
        w_out  = w_rx[10] | w_ry[10];
        w_col0 = (w_rx < XA);
        w_colm = (w_rx >= XA) && (w_rx < XB);
        w_col2 = (w_rx >= XB) && (w_rx < XC);
        w_row0 = (w_ry < Y1);
        w_rowu = (w_ry >= Y1) && (w_ry < Y2);
        w_rowm = (w_ry >= Y2) && (w_ry < Y3);
        w_rowl = (w_ry >= Y3) && (w_ry < Y4);
        w_row2 = (w_ry >= Y4) && (w_ry < Y5);
        w_in_rng    = 7'd0;
        w_in_rng[0] = !w_out && w_row0 && w_colm;
        w_in_rng[1] = !w_out && w_col2 && w_rowu;
        w_in_rng[2] = !w_out && w_col2 && w_rowl;
        w_in_rng[3] = !w_out && w_row2 && w_colm;
        w_in_rng[4] = !w_out && w_col0 && w_rowl;
        w_in_rng[5] = !w_out && w_col0 && w_rowu;
        w_in_rng[6] = !w_out && w_rowm && w_colm;
    end

    // Lit segments {g,f,e,d,c,b,a} for the latched digit; 10-15 blank.
    always_comb begin
        w_lit = 7'd0;
        case (r_digit_q)
            4'd0:    w_lit = 7'h3F;
            4'd1:    w_lit = 7'h06;
            4'd2:    w_lit = 7'h5B;
            4'd3:    w_lit = 7'h4F;
            4'd4:    w_lit = 7'h66;
            4'd5:    w_lit = 7'h6D;
            4'd6:    w_lit = 7'h7D;
            4'd7:    w_lit = 7'h07;
            4'd8:    w_lit = 7'h7F;
            4'd9:    w_lit = 7'h6F;
            default: w_lit = 7'h00;
        endcase
    end

    assign w_hit = |(r_in_rng & w_lit);

    // Stage 1: capture geometry results alongside the background pixel.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rx     <= 11'd0;
            r_ry     <= 11'd0;
            r_in_rng <= 7'd0;
            r_rgb_d  <= 24'd0;
            r_vid_d  <= 1'b0;
        end else begin
            r_rx     <= w_rx;
            r_ry     <= w_ry;
            r_in_rng <= w_in_rng;
            r_rgb_d  <= i_rgb_in;
            r_vid_d  <= i_video_on;
        end
    end

    // Stage 2: composite, forcing black outside the visible area.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rgb_out <= 24'd0;
            r_vid_out <= 1'b0;
        end else begin
            r_rgb_out <= !r_vid_d ? 24'd0 : (w_hit ? w_colour : r_rgb_d);
            r_vid_out <= r_vid_d;
        end
    end

    assign o_rgb_out       = r_rgb_out;
    assign o_video_on_out  = r_vid_out;
    assign o_digit_latched = r_digit_q;

    logic w_unused;
    assign w_unused = ^{r_rx, r_ry};

endmodule

// File: tb/tb_digit_overlay_vga.sv
// Directed-vector bench for digit_overlay_vga.
// Expected colours come from hand-derived geometry and a tiny highlight model.
module tb_digit_overlay_vga;

    localparam logic [23:0] FG = 24'hFFFFFF;
    localparam logic [23:0] HL = 24'hFF0000;
    localparam logic [23:0] BG = 24'h000080;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  digit_in;
    logic        frame_start;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        video_on;
    logic [23:0] rgb_in;
    logic [23:0] rgb_out;
    logic        video_on_out;
    logic [3:0]  digit_latched;

    int vecs = 0;
    int errs = 0;
    int m_hl = 0;
    logic [3:0] m_digit = 4'd0;

    always #5 clk = ~clk;

    digit_overlay_vga dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_digit_in     (digit_in),
        .i_frame_start  (frame_start),
        .i_hcount       (hcount),
        .i_vcount       (vcount),
        .i_video_on     (video_on),
        .i_rgb_in       (rgb_in),
        .o_rgb_out      (rgb_out),
        .o_video_on_out (video_on_out),
        .o_digit_latched(digit_latched)
    );

    function automatic logic [23:0] litc();
`ifdef DIGIT_OVL_HIGHLIGHT_EN
        return (m_hl != 0) ? HL : FG;
`else
        return FG;
`endif
    endfunction

    task automatic pix(input int h, input int v, input logic vid,
                       input logic [23:0] c);
        @(negedge clk);
        hcount   = 10'(h);
        vcount   = 10'(v);
        video_on = vid;
        rgb_in   = c;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [3:0] d);
        @(negedge clk);
        digit_in    = d;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
`ifdef DIGIT_OVL_HIGHLIGHT_EN
        if (d != m_digit) m_hl = 30;
        else if (m_hl != 0) m_hl = m_hl - 1;
`endif
        m_digit = d;
    endtask

    task automatic test_reset();
        reset = 1'b1; digit_in = 4'd0; frame_start = 1'b0;
        hcount = 10'd0; vcount = 10'd0; video_on = 1'b0; rgb_in = 24'd0;
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if (rgb_out !== 24'd0 || video_on_out !== 1'b0 || digit_latched !== 4'd0) begin
            errs++;
            $display("FAIL reset_state rgb=%h vo=%b dl=%0d want 0/0/0",
                     rgb_out, video_on_out, digit_latched);
        end
        @(negedge clk);
        reset = 1'b0;
        m_hl = 0; m_digit = 4'd0;
    endtask

    task automatic test_default_digit();
        pix(306, 201, 1'b1, BG);
        vecs++;
        if (rgb_out !== FG || video_on_out !== 1'b1) begin
            errs++;
            $display("FAIL dflt_seg_a rgb=%h vo=%b want %h/1", rgb_out, video_on_out, FG);
        end
        pix(322, 241, 1'b1, BG);
        vecs++;
        if (rgb_out !== BG) begin
            errs++;
            $display("FAIL dflt_seg_g rgb=%h want %h", rgb_out, BG);
        end
    endtask

    task automatic test_latch();
        @(negedge clk);
        digit_in = 4'd1;
        pix(306, 201, 1'b1, BG);
        vecs++;
        if (rgb_out !== FG || digit_latched !== 4'd0) begin
            errs++;
            $display("FAIL latch_hold rgb=%h dl=%0d want %h/0", rgb_out, digit_latched, FG);
        end
        frame(4'd1);
        vecs++;
        if (digit_latched !== 4'd1) begin
            errs++;
            $display("FAIL latch_dl got %0d want 1", digit_latched);
        end
        pix(306, 201, 1'b1, BG);
        vecs++;
        if (rgb_out !== BG) begin
            errs++;
            $display("FAIL latch_a_off rgb=%h want %h", rgb_out, BG);
        end
        pix(340, 210, 1'b1, BG);
        vecs++;
        if (rgb_out !== litc()) begin
            errs++;
            $display("FAIL latch_b_on rgb=%h want %h", rgb_out, litc());
        end
    endtask

    task automatic test_blank_digit();
        int hs [4] = '{306, 340, 322, 303};
        int vs [4] = '{201, 210, 241, 220};
        logic [23:0] c;
        frame(4'd12);
        for (int i = 0; i < 4; i++) begin
            c = 24'h123400 + 24'(i);
            pix(hs[i], vs[i], 1'b1, c);
            vecs++;
            if (rgb_out !== c) begin
                errs++;
                $display("FAIL blank_digit_%0d rgb=%h want %h", i, rgb_out, c);
            end
        end
    endtask

    task automatic test_edges();
        frame(4'd8);
        pix(306, 201, 1'b0, BG);
        vecs++;
        if (rgb_out !== 24'd0 || video_on_out !== 1'b0) begin
            errs++;
            $display("FAIL blanking rgb=%h vo=%b want 0/0", rgb_out, video_on_out);
        end
        pix(299, 201, 1'b1, BG);
        vecs++;
        if (rgb_out !== BG) begin
            errs++;
            $display("FAIL left_of_x0 rgb=%h want %h", rgb_out, BG);
        end
        pix(302, 202, 1'b1, BG);
        vecs++;
        if (rgb_out !== BG) begin
            errs++;
            $display("FAIL corner rgb=%h want %h", rgb_out, BG);
        end
        pix(337, 201, 1'b1, BG);
        vecs++;
        if (rgb_out !== litc()) begin
            errs++;
            $display("FAIL a_last_col rgb=%h want %h", rgb_out, litc());
        end
        pix(338, 201, 1'b1, BG);
        vecs++;
        if (rgb_out !== BG) begin
            errs++;
            $display("FAIL a_past_end rgb=%h want %h", rgb_out, BG);
        end
        pix(320, 281, 1'b1, BG);
        vecs++;
        if (rgb_out !== litc()) begin
            errs++;
            $display("FAIL d_last_row rgb=%h want %h", rgb_out, litc());
        end
        pix(320, 282, 1'b1, BG);
        vecs++;
        if (rgb_out !== BG) begin
            errs++;
            $display("FAIL below_box rgb=%h want %h", rgb_out, BG);
        end
    endtask

    task automatic test_back_to_back();
        int hs [6] = '{306, 299, 322, 303, 343, 344};
        int vs [6] = '{201, 201, 241, 250, 270, 270};
        logic [23:0] exp [6];
        exp[0] = litc(); exp[1] = 24'h000001; exp[2] = litc();
        exp[3] = litc(); exp[4] = litc();     exp[5] = 24'h000005;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                vecs++;
                if (rgb_out !== exp[i-2]) begin
                    errs++;
                    $display("FAIL b2b_%0d rgb=%h want %h", i - 2, rgb_out, exp[i-2]);
                end
            end
            if (i < 6) begin
                hcount = 10'(hs[i]); vcount = 10'(vs[i]);
                video_on = 1'b1; rgb_in = 24'(i);
            end
        end
    endtask

    task automatic test_highlight();
`ifdef DIGIT_OVL_HIGHLIGHT_EN
        frame(4'd3);
        repeat (30) frame(4'd3);
        pix(306, 201, 1'b1, BG);
        vecs++;
        if (rgb_out !== FG) begin
            errs++;
            $display("FAIL hl_idle rgb=%h want %h", rgb_out, FG);
        end
        frame(4'd4);
        pix(340, 210, 1'b1, BG);
        vecs++;
        if (rgb_out !== HL) begin
            errs++;
            $display("FAIL hl_start rgb=%h want %h", rgb_out, HL);
        end
        repeat (9) frame(4'd4);
        frame(4'd5);
        repeat (29) frame(4'd5);
        pix(306, 201, 1'b1, BG);
        vecs++;
        if (rgb_out !== HL) begin
            errs++;
            $display("FAIL hl_extended rgb=%h want %h", rgb_out, HL);
        end
        frame(4'd5);
        pix(306, 201, 1'b1, BG);
        vecs++;
        if (rgb_out !== FG) begin
            errs++;
            $display("FAIL hl_expired rgb=%h want %h", rgb_out, FG);
        end
`else
        frame(4'd3);
        frame(4'd4);
        pix(340, 210, 1'b1, BG);
        vecs++;
        if (rgb_out !== FG) begin
            errs++;
            $display("FAIL hl_disabled rgb=%h want %h", rgb_out, FG);
        end
`endif
    endtask

    task automatic test_reset_mid();
        frame(4'd7);
        pix(306, 201, 1'b1, BG);
        vecs++;
        if (rgb_out !== litc()) begin
            errs++;
            $display("FAIL pre_reset rgb=%h want %h", rgb_out, litc());
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        vecs++;
        if (rgb_out !== 24'd0 || video_on_out !== 1'b0 || digit_latched !== 4'd0) begin
            errs++;
            $display("FAIL reset_mid rgb=%h vo=%b dl=%0d want 0/0/0",
                     rgb_out, video_on_out, digit_latched);
        end
        @(negedge clk);
        digit_in = 4'd5;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        vecs++;
        if (digit_latched !== 4'd0) begin
            errs++;
            $display("FAIL reset_beats_frame dl=%0d want 0", digit_latched);
        end
        @(negedge clk);
        frame_start = 1'b0;
        reset = 1'b0;
        m_hl = 0; m_digit = 4'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        vecs++;
        if (rgb_out !== FG || video_on_out !== 1'b1) begin
            errs++;
            $display("FAIL resume rgb=%h vo=%b want %h/1", rgb_out, video_on_out, FG);
        end
    endtask

    initial begin
        test_reset();
        test_default_digit();
        test_latch();
        test_blank_digit();
        test_edges();
        test_back_to_back();
        test_highlight();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/digit_overlay_vga.md
# digit_overlay_vga

Frame-synchronous seven-segment digit renderer that draws the 0–9 value from the debounced push-button counter onto the VGA pixel stream. It sits downstream of the button counter and between the sync/pixel generator and the DAC/output pins. It latches the digit once per frame, tests each incoming pixel against the segment rectangles and replaces lit pixels with a foreground colour. All other pixels pass through unchanged, with a fixed 2-cycle latency.

## Interface
- X0, 300, left edge of digit box (pixels)
- Y0, 200, top edge of digit box (lines)
- SEG_LEN, 32, segment length (pixels)
- SEG_W, 6, segment thickness (pixels)
- FG_RGB, 24'hFFFFFF, colour of lit segments
- HL_RGB, 24'hFF0000, highlight colour (used only with the highlight macro)
- HL_FRAMES, 30, highlight duration in frames, range 1–255

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- digit_in  in  4  digit from button counter, 0–9
- frame_start  in  1  one-cycle pulse at start of vertical blank
- hcount  in  10  current pixel column
- vcount  in  10  current line
- video_on  in  1  visible-area flag, aligned with hcount/vcount
- rgb_in  in  24  background pixel, aligned with hcount/vcount
- rgb_out  out  24  composited pixel
- video_on_out  out  1  video_on delayed to match rgb_out
- digit_latched  out  4  digit currently displayed

## Operation
- **Digit latch.** digit_q <= digit_in only on a cycle with frame_start=1. Changes to digit_in mid-frame are ignored until the next frame_start.
- **Segment decode** of digit_q:
  - 0 = abcdef, 1 = bc, 2 = abdeg, 3 = abcdg, 4 = bcfg
  - 5 = acdfg, 6 = acdefg, 7 = abc, 8 = abcdefg, 9 = abcdfg
  - 10–15 = no segments (blank)
- **Relative coordinates.** rx = hcount − X0 and ry = vcount − Y0, computed 11 bits wide. A negative result (bit 10 set) means the pixel is outside the box.
- **Segment geometry.** Let S = SEG_W and L = SEG_LEN; all ranges are half-open.
  - a: ry∈[0,S), rx∈[S,S+L)
  - g: ry∈[S+L,2S+L), rx∈[S,S+L)
  - d: ry∈[2S+2L,3S+2L), rx∈[S,S+L)
  - f: rx∈[0,S), ry∈[S,S+L)
  - e: rx∈[0,S), ry∈[2S+L,2S+2L)
  - b: rx∈[S+L,2S+L), ry as f
  - c: rx∈[S+L,2S+L), ry as e
  - Corner squares belong to no segment.
- **Pipeline stage 1** registers:
  - rx, ry, and the per-segment in-range flags
  - rgb_in and video_on
- **Pipeline stage 2** registers:
  - hit = OR over segments of (in_range & lit)
  - rgb_out = !video_on_d ? 0 : hit ? colour : rgb_in_d
  - video_on_out = video_on_d
- **Reset values:**
  - digit_q = 0, so the display shows "0", matching the upstream counter's reset value
  - digit_latched = 0
  - pipeline registers = 0, rgb_out = 0, video_on_out = 0
  - hl_cnt = 0

## Timing
- rgb_out and video_on_out lag hcount, vcount, rgb_in and video_on by exactly 2 clk cycles.
- The sync generator must delay hsync/vsync by 2 cycles to stay aligned.
- digit_latched updates on the clock edge that samples frame_start. Pixels of the following frame use the new digit. frame_start must fall in vertical blank, so no frame tears.
- Reset asserted together with frame_start: reset wins.
- Reset asserted mid-frame: all outputs are 0 on the next cycle. Normal output resumes 2 cycles after reset deasserts.
- hcount/vcount wrap (e.g. 799→0) needs no special handling; the comparisons are purely combinational per pixel.

## Configuration
- Macro: DIGIT_OVL_HIGHLIGHT_EN.
- **Defined:** an 8-bit hl_cnt is added.
  - On frame_start, if digit_in ≠ digit_q, hl_cnt loads HL_FRAMES.
  - Otherwise, on frame_start, hl_cnt decrements if nonzero.
  - While hl_cnt ≠ 0, lit pixels use HL_RGB; otherwise they use FG_RGB.
  - A new change during an active highlight reloads hl_cnt to HL_FRAMES.
- **Undefined:** no hl_cnt register is present and lit pixels always use FG_RGB. HL_RGB and HL_FRAMES are ignored.

## Test plan
- **Default digit after reset.** Reset, then video_on=1, rgb_in=24'h000080, pixel (306,201) → rgb_out=24'hFFFFFF 2 cycles later; pixel (322,241) (segment g) → rgb_out=24'h000080.
- **Latch only at frame boundary.** digit_in 0→1 mid-frame → pixel (306,201) stays FG until frame_start. After frame_start it passes rgb_in, while pixel (340,210) (segment b) is FG. digit_latched=1.
- **Out-of-range digit.** digit_in=4'd12 latched → every pixel in the box passes rgb_in unchanged.
- **Blanking and box edges.** video_on=0 → rgb_out=0 and video_on_out=0 regardless of position. Pixel (299,201) (left of X0) → rgb_in passthrough.
- **Highlight, macro defined.** Change 3→4 at frame_start → lit pixels are 24'hFF0000 for 30 frames, then 24'hFFFFFF. A change 4→5 at frame 10 → highlight extends to 30 frames after that point. Macro undefined → always 24'hFFFFFF.
- **Reset mid-operation.** Assert reset mid-frame with highlight active and digit_q=7 → next cycle rgb_out=0, digit_latched=0 and hl_cnt=0. Outputs resume correctly 2 cycles after reset release.
